// File: rtl/square_reg_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// square_reg_file: pulse channel register front end and length counter. Rev 1.0
// ---------------------------------------------------------------------------
module square_reg_file #(
  parameter logic [15:0] BASE_ADDR  = 16'h4000,
  parameter int          STATUS_BIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic        half_frame,
  output logic [7:0]  cpu_rdata,
  output logic [7:0]  r4000,
  output logic [7:0]  r4001,
  output logic [7:0]  r4002,
  output logic [7:0]  r4003,
  output logic        restart,
  output logic        sweep_reload,
  output logic [7:0]  len_count,
  output logic        active
);

  localparam logic [15:0] C_STATUS_ADDR = 16'h4015;

  logic [7:0] r4000_q, r4000_d, r4001_q, r4001_d;
  logic [7:0] r4002_q, r4002_d, r4003_q, r4003_d;
  logic [7:0] len_q, len_d, rdata_q, rdata_d;
  logic       enable_q, enable_d;
  logic       restart_q, restart_d, sweep_q, sweep_d;

  logic w_wr0, w_wr1, w_wr2, w_wr3, w_wr_status, w_rd_status;

  function automatic logic [7:0] len_lookup(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
      5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
      5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
      5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
      5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
      5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
    endcase
    return v;
  endfunction

  assign w_wr0       = cpu_we && (cpu_addr == BASE_ADDR);
  assign w_wr1       = cpu_we && (cpu_addr == BASE_ADDR + 16'd1);
  assign w_wr2       = cpu_we && (cpu_addr == BASE_ADDR + 16'd2);
  assign w_wr3       = cpu_we && (cpu_addr == BASE_ADDR + 16'd3);
  assign w_wr_status = cpu_we && (cpu_addr == C_STATUS_ADDR);
  assign w_rd_status = cpu_re && (cpu_addr == C_STATUS_ADDR);

  always_comb begin
    r4000_d   = w_wr0 ? cpu_wdata : r4000_q;
    r4001_d   = w_wr1 ? cpu_wdata : r4001_q;
    r4002_d   = w_wr2 ? cpu_wdata : r4002_q;
    r4003_d   = w_wr3 ? cpu_wdata : r4003_q;
    enable_d  = w_wr_status ? cpu_wdata[STATUS_BIT] : enable_q;
    restart_d = w_wr3;
    sweep_d   = w_wr1;

    // Disable beats a length load, which beats a tick; halt uses pre-edge r4000.
    if (w_wr_status && !cpu_wdata[STATUS_BIT])
      len_d = 8'd0;
    else if (w_wr3 && enable_q)
      len_d = len_lookup(cpu_wdata[7:3]);
    else if (half_frame && (len_q != 8'd0) && !r4000_q[5])
      len_d = len_q - 8'd1;
    else
      len_d = len_q;

    rdata_d = 8'd0;
    if (w_rd_status)
      rdata_d[STATUS_BIT] = (len_q != 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r4000_q   <= 8'd0;
      r4001_q   <= 8'd0;
      r4002_q   <= 8'd0;
      r4003_q   <= 8'd0;
      len_q     <= 8'd0;
      rdata_q   <= 8'd0;
      enable_q  <= 1'b0;
      restart_q <= 1'b0;
      sweep_q   <= 1'b0;
    end else begin
      r4000_q   <= r4000_d;
      r4001_q   <= r4001_d;
      r4002_q   <= r4002_d;
      r4003_q   <= r4003_d;
      len_q     <= len_d;
      rdata_q   <= rdata_d;
      enable_q  <= enable_d;
      restart_q <= restart_d;
      sweep_q   <= sweep_d;
    end
  end

  assign r4000        = r4000_q;
  assign r4001        = r4001_q;
  assign r4002        = r4002_q;
  assign r4003        = r4003_q;
  assign len_count    = len_q;
  assign active       = (len_q != 8'd0);
  assign cpu_rdata    = rdata_q;
  assign restart      = restart_q;
  assign sweep_reload = sweep_q;

endmodule
`default_nettype wire

// File: tb/tb_square_reg_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_square_reg_file: directed bench for both pulse-channel register fronts. Rev 1.0
// ---------------------------------------------------------------------------
module tb_square_reg_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic        half_frame = 1'b0;

  logic [7:0] p1_rdata, p1_r4000, p1_r4001, p1_r4002, p1_r4003, p1_len;
  logic       p1_restart, p1_sweep, p1_active;
  logic [7:0] p2_rdata, p2_r4000, p2_r4001, p2_r4002, p2_r4003, p2_len;
  logic       p2_restart, p2_sweep, p2_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  square_reg_file #(.BASE_ADDR(16'h4000), .STATUS_BIT(0)) u_p1 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .half_frame(half_frame),
    .cpu_rdata(p1_rdata), .r4000(p1_r4000), .r4001(p1_r4001), .r4002(p1_r4002),
    .r4003(p1_r4003), .restart(p1_restart), .sweep_reload(p1_sweep),
    .len_count(p1_len), .active(p1_active)
  );

  square_reg_file #(.BASE_ADDR(16'h4004), .STATUS_BIT(1)) u_p2 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .half_frame(half_frame),
    .cpu_rdata(p2_rdata), .r4000(p2_r4000), .r4001(p2_r4001), .r4002(p2_r4002),
    .r4003(p2_r4003), .restart(p2_restart), .sweep_reload(p2_sweep),
    .len_count(p2_len), .active(p2_active)
  );

  // Drive one bus cycle from a falling edge; returns at the next falling edge.
  task automatic bus(input logic we, input logic re, input logic hf,
                     input logic [15:0] addr, input logic [7:0] data);
    cpu_we = we; cpu_re = re; half_frame = hf; cpu_addr = addr; cpu_wdata = data;
    @(negedge clk);
    cpu_we = 1'b0; cpu_re = 1'b0; half_frame = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({p1_r4000, p1_r4001, p1_r4002, p1_r4003, p1_len, p1_rdata} !== 48'h0) begin
      errors++; $display("FAIL reset_p1_bytes got %h required 0",
                         {p1_r4000, p1_r4001, p1_r4002, p1_r4003, p1_len, p1_rdata});
    end
    checks++;
    if ({p1_restart, p1_sweep, p1_active, p2_restart, p2_sweep, p2_active} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes got %b required 0",
                         {p1_restart, p1_sweep, p1_active, p2_restart, p2_sweep, p2_active});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_length_load();
    bus(1, 0, 0, 16'h4015, 8'h01);
    bus(1, 0, 0, 16'h4003, 8'h08);
    checks++;
    if (p1_r4003 !== 8'h08) begin errors++; $display("FAIL load_r4003 got %h required 08", p1_r4003); end
    checks++;
    if (p1_len !== 8'd254) begin errors++; $display("FAIL load_len got %0d required 254", p1_len); end
    checks++;
    if (p1_active !== 1'b1) begin errors++; $display("FAIL load_active got %b required 1", p1_active); end
    checks++;
    if (p1_restart !== 1'b1) begin errors++; $display("FAIL restart_high got %b required 1", p1_restart); end
    bus(1, 1, 0, 16'h4015, 8'h00 | 8'h01);
    checks++;
    if (p1_restart !== 1'b0) begin errors++; $display("FAIL restart_one_cycle got %b required 0", p1_restart); end
    checks++;
    if (p1_rdata !== 8'h01) begin errors++; $display("FAIL read_active got %h required 01", p1_rdata); end
    bus(0, 1, 0, 16'h4014, 8'h00);
    checks++;
    if (p1_rdata !== 8'h00) begin errors++; $display("FAIL read_other_addr got %h required 00", p1_rdata); end
  endtask

  task automatic test_decrement();
    for (int i = 0; i < 3; i++) bus(0, 0, 1, 16'h0000, 8'h00);
    checks++;
    if (p1_len !== 8'd251) begin errors++; $display("FAIL dec3 got %0d required 251", p1_len); end
    bus(1, 0, 0, 16'h4000, 8'h20);
    checks++;
    if (p1_r4000 !== 8'h20) begin errors++; $display("FAIL r4000_write got %h required 20", p1_r4000); end
    for (int i = 0; i < 2; i++) bus(0, 0, 1, 16'h0000, 8'h00);
    checks++;
    if (p1_len !== 8'd251) begin errors++; $display("FAIL halt_hold got %0d required 251", p1_len); end
    bus(1, 0, 1, 16'h4000, 8'h00);
    checks++;
    if (p1_len !== 8'd251) begin errors++; $display("FAIL halt_preedge got %0d required 251", p1_len); end
    bus(0, 0, 1, 16'h0000, 8'h00);
    checks++;
    if (p1_len !== 8'd250) begin errors++; $display("FAIL unhalt_dec got %0d required 250", p1_len); end
  endtask

  task automatic test_priority();
    bus(1, 0, 0, 16'h4003, 8'h18);
    checks++;
    if (p1_len !== 8'd2) begin errors++; $display("FAIL load_idx3 got %0d required 2", p1_len); end
    bus(1, 0, 1, 16'h4003, 8'hF8);
    checks++;
    if (p1_len !== 8'd30) begin errors++; $display("FAIL load_over_tick got %0d required 30", p1_len); end
    bus(1, 0, 1, 16'h4015, 8'h00);
    checks++;
    if (p1_len !== 8'd0 || p1_active !== 1'b0) begin
      errors++; $display("FAIL disable_over_tick got %0d/%b required 0/0", p1_len, p1_active);
    end
    bus(0, 0, 1, 16'h0000, 8'h00);
    checks++;
    if (p1_len !== 8'd0) begin errors++; $display("FAIL no_wrap got %0d required 0", p1_len); end
  endtask

  task automatic test_disabled_load();
    bus(1, 0, 0, 16'h4003, 8'h18);
    checks++;
    if (p1_r4003 !== 8'h18 || p1_restart !== 1'b1) begin
      errors++; $display("FAIL disabled_write got %h/%b required 18/1", p1_r4003, p1_restart);
    end
    checks++;
    if (p1_len !== 8'd0) begin errors++; $display("FAIL disabled_no_load got %0d required 0", p1_len); end
    bus(0, 1, 0, 16'h4015, 8'h00);
    checks++;
    if (p1_rdata !== 8'h00) begin errors++; $display("FAIL disabled_read got %h required 00", p1_rdata); end
  endtask

  task automatic test_pulse2();
    bus(1, 0, 0, 16'h4001, 8'h87);
    checks++;
    if (p2_r4001 !== 8'h00 || p2_sweep !== 1'b0) begin
      errors++; $display("FAIL p2_wrong_addr got %h/%b required 00/0", p2_r4001, p2_sweep);
    end
    checks++;
    if (p1_sweep !== 1'b1) begin errors++; $display("FAIL p1_sweep got %b required 1", p1_sweep); end
    bus(1, 0, 0, 16'h4005, 8'h87);
    checks++;
    if (p2_r4001 !== 8'h87 || p2_sweep !== 1'b1) begin
      errors++; $display("FAIL p2_sweep_write got %h/%b required 87/1", p2_r4001, p2_sweep);
    end
    @(negedge clk);
    checks++;
    if (p2_sweep !== 1'b0) begin errors++; $display("FAIL p2_sweep_once got %b required 0", p2_sweep); end
    bus(1, 0, 0, 16'h4015, 8'h02);
    bus(1, 0, 0, 16'h4007, 8'h00);
    checks++;
    if (p2_len !== 8'd10) begin errors++; $display("FAIL p2_len got %0d required 10", p2_len); end
    bus(0, 1, 0, 16'h4015, 8'h00);
    checks++;
    if (p2_rdata !== 8'h02 || p1_rdata !== 8'h00) begin
      errors++; $display("FAIL p2_read got %h/%h required 02/00", p2_rdata, p1_rdata);
    end
  endtask

  task automatic test_async_reset();
    bus(1, 0, 0, 16'h4015, 8'h01);
    bus(1, 0, 0, 16'h4003, 8'h40);
    for (int i = 0; i < 60; i++) bus(0, 0, 1, 16'h0000, 8'h00);
    checks++;
    if (p1_len !== 8'd100) begin errors++; $display("FAIL count_to_100 got %0d required 100", p1_len); end
    bus(1, 0, 0, 16'h4001, 8'h55);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({p1_len, p1_r4001, p1_r4003, p1_rdata} !== 32'h0 || {p1_active, p1_sweep, p1_restart} !== 3'b0) begin
      errors++; $display("FAIL async_reset got %h %b required 0",
                         {p1_len, p1_r4001, p1_r4003, p1_rdata}, {p1_active, p1_sweep, p1_restart});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus(1, 0, 0, 16'h4003, 8'h08);
    checks++;
    if (p1_len !== 8'd0 || p1_r4003 !== 8'h08) begin
      errors++; $display("FAIL post_reset_disabled got %0d/%h required 0/08", p1_len, p1_r4003);
    end
    bus(1, 0, 0, 16'h4015, 8'h01);
    bus(1, 0, 0, 16'h4003, 8'h08);
    checks++;
    if (p1_len !== 8'd254) begin errors++; $display("FAIL post_reset_enabled got %0d required 254", p1_len); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_length_load();
    test_decrement();
    test_priority();
    test_disabled_load();
    test_pulse2();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/square_reg_file.md
# square_reg_file

CPU-side register front end for one pulse channel of the APU. Decodes CPU bus writes to the channel's four registers ($4000–$4003 for pulse 1, $4004–$4007 for pulse 2) and presents them as the r4000..r4003 bytes consumed by `square`. Also owns the channel's length counter, its enable bit in $4015, and the one-shot side-effect strobes that register writes trigger. Sits between the CPU bus decoder and the `square` instance.

## Interface
- BASE_ADDR, 16'h4000: address of the channel's first register; 16'h4004 for pulse 2.
- STATUS_BIT, 0: bit of $4015 used for this channel's enable on write and length status on read; 1 for pulse 2.

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_we  in  1  write strobe, one cycle per write
- cpu_re  in  1  read strobe, one cycle per read
- half_frame  in  1  one-cycle half-frame tick from the frame counter
- cpu_rdata  out  8  $4015 read contribution
- r4000, r4001, r4002, r4003  out  8 each  latched register bytes to `square`
- restart  out  1  one-cycle pulse after a write to BASE_ADDR+3
- sweep_reload  out  1  one-cycle pulse after a write to BASE_ADDR+1
- len_count  out  8  current length counter
- active  out  1  len_count != 0

## Operation
- Register writes: cpu_we high and cpu_addr == BASE_ADDR+n (n = 0..3) loads cpu_wdata into r400n. Any other address leaves r4000..r4003 unchanged.
- Enable: cpu_we high and cpu_addr == 16'h4015 loads the enable flag from cpu_wdata[STATUS_BIT]. Writing 0 clears len_count to 0. While disabled, len_count stays 0.
- Length load: on a write to BASE_ADDR+3 with the enable flag set (its value before this edge), load len_count = LEN[cpu_wdata[7:3]].
  - LEN[0..31] = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
  - If disabled, r4003 still updates and restart still pulses, but len_count is not loaded.
- Length decrement: on half_frame, if len_count != 0 and halt (r4000[5]) == 0, decrement len_count by 1. It never wraps below 0.
- Priority in the same cycle: $4015 disable clear > BASE+3 load > half_frame decrement. A suppressed decrement is discarded, not deferred.
- Halt is taken from r4000 as it stands before the edge. A same-cycle write to r4000 affects only later ticks.
- Strobes: restart and sweep_reload are registered. Each is high for exactly one cycle per qualifying write; back-to-back writes give back-to-back pulses.
- Read: cpu_re high with cpu_addr == 16'h4015 registers cpu_rdata = active << STATUS_BIT, with all other bits 0. Any other read, or no read, registers cpu_rdata = 0.
- Reads have no side effects in this block.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - all outputs to 0: r4000..r4003, cpu_rdata, restart, sweep_reload, len_count, active;
  - the enable flag to 0.
- Reset is effective immediately, mid-operation included; a pending strobe is dropped. The first write is accepted on the first rising clk edge with rst_n high.
- Write latency: r400n, the enable flag and len_count update on the edge that samples cpu_we. New values are visible in the cycle after the write.
- restart and sweep_reload are asserted in the cycle after the write edge.
- active is combinational from len_count, with no extra latency.
- cpu_rdata is valid in the cycle after cpu_re. It reflects len_count before that edge.
- No handshake or back-pressure: every strobe is accepted in its cycle.

## Test plan
- Reset, then write $4015 = 8'h01, then $4003 = 8'h08 (index 1) -> the next cycle shows r4003 = 8'h08, len_count = 254, active = 1, restart high for exactly 1 cycle.
- With len_count = 254 and r4000 = 8'h00, apply 3 half_frame pulses -> len_count = 251. Write r4000 = 8'h20, apply 2 more pulses -> len_count stays 251.
- With len_count = 2 and enable set, apply half_frame in the same cycle as writing $4003 = 8'hF8 (index 31) -> len_count = 30. Then write $4015 = 8'h00 in the same cycle as half_frame -> len_count = 0.
- Enable clear, then write $4003 = 8'h18 -> r4003 = 8'h18, restart pulses, len_count = 0, and a $4015 read returns cpu_rdata = 8'h00.
- With STATUS_BIT = 1 and BASE_ADDR = 16'h4004:
  - write $4001 = 8'h87 -> r4001 stays 0, no sweep_reload;
  - write $4005 = 8'h87 -> r4001 = 8'h87, sweep_reload pulses once;
  - write $4015 = 8'h02, then $4007 = 8'h00 -> a $4015 read returns 8'h02 one cycle later.
- Assert rst_n low asynchronously mid-count (len_count = 100), between clock edges -> all outputs go to 0 immediately. After release, $4003 writes do not load len_count until $4015 is written with the enable bit set.
